muldiv_multicycle_unit: RTL and testbench

//  Parametrised multicycle unsigned multiply/divide unit. It is the successor to controlUnitFSM.
//  It merges the start/mode-driven control FSM with its shift-add / restoring-divide datapath.

---
 rtl/muldiv_pkg.sv | 10 +
 rtl/muldiv_datapath.sv | 52 +++++
 rtl/muldiv_multicycle_unit.sv | 92 +++++++++
 tb/tb_muldiv_multicycle_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: state/sel codes and mode encodings shared by the multiply/divide unit
package muldiv_pkg;
  localparam logic [2:0] ST_IDLE     = 3'b000;
  localparam logic [2:0] ST_LOAD     = 3'b001;
  localparam logic [2:0] ST_MUL_STEP = 3'b010;
  localparam logic [2:0] ST_DIV_STEP = 3'b011;
  localparam logic [2:0] ST_FINISH   = 3'b100;
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: A/Q/B/counter registers with one shared adder/subtractor for shift-add multiply and restoring divide
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             e,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             last
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] a, q, b;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rs;
  logic [WIDTH+1:0] alu;
  logic             is_mul, ge;
  assign is_mul = sel == ST_MUL_STEP;
  // divide shifts {R,Q} left first; the extra top bit keeps the shifted remainder exact
  assign rs = {a, q[WIDTH-1]};
  // one extra bit above the carry serves as the borrow flag when subtracting
  assign alu = is_mul ? {2'b00, a} + {2'b00, (q[0] ? b : {WIDTH{1'b0}})}
                      : {1'b0, rs} - {2'b00, b};
  assign ge = ~alu[WIDTH+1];
  assign a_next = is_mul ? alu[WIDTH:1] : (ge ? alu[WIDTH-1:0] : rs[WIDTH-1:0]);
  assign q_next = is_mul ? {alu[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ge};
  assign last = cnt == CNT_W'(1);
  // load initialises the working registers, e advances one step
  always_ff @(posedge clock) begin
    if (!reset) begin
      a   <= '0;
      q   <= '0;
      b   <= '0;
      cnt <= '0;
    end else if (load) begin
      a   <= '0;
      q   <= op_a;
      b   <= op_b;
      cnt <= CNT_W'(WIDTH);
    end else if (e) begin
      a   <= a_next;
      q   <= q_next;
      cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

// File: rtl/muldiv_multicycle_unit.sv
// muldiv_multicycle_unit: multicycle unsigned multiply/divide with control FSM, captured operands and held results
module muldiv_multicycle_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero,
  output logic             e,
  output logic [2:0]       sel
);
  logic [2:0]       state, state_next;
  logic             mode_r, last, accept, div_zero, step_done;
  logic [WIDTH-1:0] a_r, b_r, a_next, q_next;
  assign accept    = state == ST_IDLE && start;
  assign div_zero  = mode_r == MODE_DIV && b_r == '0;
  assign step_done = (state == ST_MUL_STEP || state == ST_DIV_STEP) && last;
  // state codes double as sel, so sel is the state register itself
  assign sel = state;
  // state register
  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end
  // next-state logic; FINISH and illegal codes fall back to IDLE
  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE:     state_next = start ? ST_LOAD : ST_IDLE;
      ST_LOAD:     state_next = div_zero ? ST_FINISH : (mode_r == MODE_DIV ? ST_DIV_STEP : ST_MUL_STEP);
      ST_MUL_STEP,
      ST_DIV_STEP: state_next = last ? ST_FINISH : state;
      default:     state_next = ST_IDLE;
    endcase
  end
  // state-decoded outputs
  always_comb begin
    busy = state != ST_IDLE;
    done = state == ST_FINISH;
    e    = state == ST_MUL_STEP || state == ST_DIV_STEP;
  end
  // operands and mode are captured only when a start is accepted
  always_ff @(posedge clock) begin
    if (!reset) begin
      mode_r <= MODE_MUL;
      a_r    <= '0;
      b_r    <= '0;
    end else if (accept) begin
      mode_r <= mode;
      a_r    <= op_a;
      b_r    <= op_b;
    end
  end
  // results load on the edge entering FINISH, taking the final step's next values
  always_ff @(posedge clock) begin
    if (!reset) begin
      result_hi   <= '0;
      result_lo   <= '0;
      div_by_zero <= 1'b0;
    end else if (step_done) begin
      result_hi <= a_next;
      result_lo <= q_next;
    end else if (state == ST_LOAD && div_zero) begin
      result_hi   <= a_r;
      result_lo   <= '1;
      div_by_zero <= 1'b1;
    end else if (accept) begin
      div_by_zero <= 1'b0;
    end
  end
  muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .clock  (clock),
    .reset  (reset),
    .load   (state == ST_LOAD),
    .e      (e),
    .sel    (state),
    .op_a   (a_r),
    .op_b   (b_r),
    .a_next (a_next),
    .q_next (q_next),
    .last   (last)
  );
endmodule

// File: tb/tb_muldiv_multicycle_unit.sv
// tb_muldiv_multicycle_unit: directed vectors with a result scoreboard checked on each done pulse
module tb_muldiv_multicycle_unit;
  localparam int W = 8;
  logic         clock = 1'b0, reset = 1'b0, start = 1'b0, mode = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         busy, done, div_by_zero, e;
  logic [W-1:0] result_hi, result_lo;
  logic [2:0]   sel;
  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;
  exp_t         sb[$];
  exp_t         got;
  int           checks = 0, fails = 0;
  logic [W-1:0] prev_hi = '0, prev_lo = '0;
  muldiv_multicycle_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .result_hi   (result_hi),
    .result_lo   (result_lo),
    .div_by_zero (div_by_zero),
    .e           (e),
    .sel         (sel)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: done=1 with no outstanding op at %0t", $time);
      end else begin
        got = sb.pop_front();
        chk("sb_result_hi", result_hi, got.hi);
        chk("sb_result_lo", result_lo, got.lo);
        chk("sb_div_by_zero", div_by_zero, got.dbz);
      end
    end
  end
  // issue one op and walk its cycles, checking control outputs and held results every cycle
  task automatic run_op(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dbz,
                        input int rst_at, input bit repulse);
    int   last;
    logic in_op;
    logic [2:0] es;
    last = (m && b == '0) ? 2 : W + 2;
    if (rst_at == 0) sb.push_back({hi, lo, dbz});
    start = 1'b1;
    mode  = m;
    op_a  = a;
    op_b  = b;
    @(negedge clock);
    start = 1'b0;
    mode  = ~m;
    op_a  = ~a;
    op_b  = ~b;
    for (int c = 1; c <= last + 2; c++) begin
      in_op = (rst_at == 0) || (c <= rst_at);
      es = !in_op ? 3'b000 : c == 1 ? 3'b001 : c == last ? 3'b100 :
           c < last ? (m ? 3'b011 : 3'b010) : 3'b000;
      chk("busy", busy, in_op && c <= last);
      chk("e", e, in_op && c > 1 && c < last);
      chk("done", done, in_op && c == last);
      chk("sel", sel, es);
      chk("result_hi", result_hi, !in_op ? '0 : c < last ? prev_hi : hi);
      chk("result_lo", result_lo, !in_op ? '0 : c < last ? prev_lo : lo);
      chk("div_by_zero", div_by_zero, (in_op && c >= last) ? dbz : 1'b0);
      if (repulse && (c == 4 || c == last)) begin
        start = 1'b1;
        mode  = 1'b0;
        op_a  = 8'h77;
        op_b  = 8'h02;
      end else start = 1'b0;
      reset = !(rst_at != 0 && c == rst_at);
      @(negedge clock);
    end
    start = 1'b0;
    reset = 1'b1;
    prev_hi = (rst_at == 0) ? hi : '0;
    prev_lo = (rst_at == 0) ? lo : '0;
  endtask
  initial begin
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_e", e, 0);
    chk("rst_sel", sel, 0);
    chk("rst_hi", result_hi, 0);
    chk("rst_lo", result_lo, 0);
    chk("rst_dbz", div_by_zero, 0);
    reset = 1'b1;
    @(negedge clock);
    run_op(1'b0, 8'd13,  8'd11,  8'h00, 8'h8F, 1'b0, 0, 1'b0);
    run_op(1'b0, 8'd255, 8'd255, 8'hFE, 8'h01, 1'b0, 0, 1'b0);
    run_op(1'b1, 8'd200, 8'd7,   8'h04, 8'h1C, 1'b0, 0, 1'b0);
    run_op(1'b1, 8'h55,  8'h00,  8'h55, 8'hFF, 1'b1, 0, 1'b0);
    run_op(1'b0, 8'd3,   8'd5,   8'h00, 8'h0F, 1'b0, 0, 1'b0);
    run_op(1'b0, 8'd100, 8'd3,   8'h01, 8'h2C, 1'b0, 0, 1'b1);
    run_op(1'b0, 8'd50,  8'd50,  8'h00, 8'h00, 1'b0, 5, 1'b0);
    run_op(1'b1, 8'd255, 8'd16,  8'h0F, 8'h0F, 1'b0, 0, 1'b0);
    run_op(1'b1, 8'd7,   8'd9,   8'h07, 8'h00, 1'b0, 0, 1'b0);
    run_op(1'b1, 8'd255, 8'd1,   8'h00, 8'hFF, 1'b0, 0, 1'b0);
    run_op(1'b0, 8'd0,   8'd200, 8'h00, 8'h00, 1'b0, 0, 1'b0);
    repeat (3) @(negedge clock);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
